// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants and types for the I2S transmitter.
//   FRAME_BITS   : BCK periods per stereo frame (two 32-bit slots)
//   SLOT_BITS    : BCK periods per channel slot
//   SAMPLE_W_DEF : default PCM sample width used by the top level
//   bit_idx_t    : frame bit index, 0..63
//   sample_pair_t: stereo pair at the default sample width
//   pair_t       : stereo pair with each sample MSB-justified in a full slot
//   ws_for_bit() : word-select level for a given frame bit index
package i2s_pkg;

    localparam int FRAME_BITS   = 64;
    localparam int SLOT_BITS    = 32;
    localparam int SAMPLE_W_DEF = 16;

    typedef logic [5:0] bit_idx_t;

    typedef struct packed {
        logic [SAMPLE_W_DEF-1:0] left;
        logic [SAMPLE_W_DEF-1:0] right;
    } sample_pair_t;

    // Samples are stored MSB-justified in their slot so the unused tail of
    // each slot is already zero and the frame can be shifted out verbatim.
    typedef struct packed {
        logic [SLOT_BITS-1:0] left;
        logic [SLOT_BITS-1:0] right;
    } pair_t;

    // WS leads each slot by one bit: high for bits 31..62.
    function automatic logic ws_for_bit(input bit_idx_t b);
        return (b >= 6'd31) && (b <= 6'd62);
    endfunction

endpackage

// File: rtl/i2s_bck_gen.sv
// i2s_bck_gen: bit-clock generator.
//   clk    : system clock
//   reset  : synchronous, active-high
//   bck_o  : registered bit clock, half-period of BCK_DIV clk cycles
//   rise_o : one-cycle strobe in the cycle whose edge drives BCK 0->1
//   fall_o : one-cycle strobe in the cycle whose edge drives BCK 1->0
module i2s_bck_gen #(
    parameter int BCK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic bck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam logic [CNT_W-1:0] TC = CNT_W'(BCK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             bck_q, bck_d;
    logic             tc;

    always_comb begin
        tc        = (div_cnt_q == TC);
        div_cnt_d = tc ? '0 : div_cnt_q + 1'b1;
        bck_d     = tc ? ~bck_q : bck_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            bck_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bck_q     <= bck_d;
        end
    end

    // Strobes mark the cycle before BCK changes, so logic clocked by the
    // same edge updates together with BCK.
    assign bck_o  = bck_q;
    assign rise_o = tc & ~bck_q;
    assign fall_o = tc & bck_q;

endmodule

// File: rtl/i2s_frame_tx.sv
// i2s_frame_tx: single-clock I2S transmitter with a one-pair holding register.
//   clk, reset        : clock, synchronous active-high reset
//   sample_l/sample_r : stereo PCM pair, two's complement, SAMPLE_W bits each
//   valid / ready     : pair handshake; ready is high while the holding register is empty
//   underflow_clr     : clears the sticky underflow flag (a simultaneous set wins)
//   I2S_BCK_o         : bit clock
//   I2S_WS_o          : word select, 0 = left, 1 = right
//   I2S_DATA_o        : serial data, MSB first, one bit after WS
//   underflow         : sticky, a frame started with the holding register empty
// Build option I2S_TX_UNDERFLOW_MUTE_EN: when defined an underflow frame is
// all zeros; otherwise it repeats the last loaded pair (zero after reset).
module i2s_frame_tx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int BCK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                valid,
    output logic                ready,
    input  logic                underflow_clr,
    output logic                I2S_BCK_o,
    output logic                I2S_WS_o,
    output logic                I2S_DATA_o,
    output logic                underflow
);

    function automatic logic [SLOT_BITS-1:0] justify(input logic [SAMPLE_W-1:0] s);
        logic [SLOT_BITS-1:0] slot;
        slot = '0;
        slot[SLOT_BITS-1 -: SAMPLE_W] = s;
        return slot;
    endfunction

    logic bck_rise, bck_fall;

    i2s_bck_gen #(
        .BCK_DIV (BCK_DIV)
    ) u_bck_gen (
        .clk    (clk),
        .reset  (reset),
        .bck_o  (I2S_BCK_o),
        .rise_o (bck_rise),
        .fall_o (bck_fall)
    );

    bit_idx_t                bit_q, bit_d;
    logic                    ws_q, ws_d;
    logic                    data_q, data_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    pair_t                   hold_q, hold_d;
    logic                    ready_q, ready_d;
    logic                    underflow_q, underflow_d;
    logic [FRAME_BITS-1:0]   uf_src;
    logic [FRAME_BITS-1:0]   frame;
    logic                    accept;
    logic                    load;

`ifdef I2S_TX_UNDERFLOW_MUTE_EN
    assign uf_src = '0;
`else
    pair_t last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (load && !ready_q) begin
            last_d = hold_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end

    assign uf_src = last_q;
`endif

    always_comb begin
        accept      = valid & ready_q;
        load        = bck_fall & (bit_q == bit_idx_t'(FRAME_BITS - 1));
        bit_d       = bit_q;
        ws_d        = ws_q;
        data_d      = data_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        ready_d     = ready_q;
        underflow_d = underflow_q;
        frame       = shift_q;

        // Accept and a full-register load are mutually exclusive; an accept
        // on an underflow load cycle lands in hold for the following frame.
        if (accept) begin
            hold_d.left  = justify(sample_l);
            hold_d.right = justify(sample_r);
            ready_d      = 1'b0;
        end

        if (bck_fall) begin
            bit_d = bit_idx_t'(bit_q + 1'b1);
            ws_d  = ws_for_bit(bit_d);
            if (load) begin
                if (ready_q) begin
                    frame = uf_src;
                end else begin
                    frame   = hold_q;
                    ready_d = 1'b1;
                end
            end
            data_d  = frame[FRAME_BITS-1];
            shift_d = frame << 1;
        end

        if (load && ready_q) begin
            underflow_d = 1'b1;
        end else if (underflow_clr) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_q       <= bit_idx_t'(FRAME_BITS - 1);
            ws_q        <= 1'b0;
            data_q      <= 1'b0;
            shift_q     <= '0;
            hold_q      <= '0;
            ready_q     <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            bit_q       <= bit_d;
            ws_q        <= ws_d;
            data_q      <= data_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            ready_q     <= ready_d;
            underflow_q <= underflow_d;
        end
    end

    assign ready      = ready_q;
    assign underflow  = underflow_q;
    assign I2S_WS_o   = ws_q;
    assign I2S_DATA_o = data_q;

endmodule
